// File: rtl/kernel_cc_fifo_rd_s_pkg.sv
// Shared widths and helpers for the kernel_cc FIFO read-side stream client.
package kernel_cc_fifo_rd_s_pkg;

    localparam int unsigned KCC_FIFO_W = 64;
    localparam int unsigned KCC_BEAT_W = 32;
    localparam int unsigned KCC_LEN_W  = 16;

    // Lane index width for a given slice ratio; never narrower than one bit.
    function automatic int unsigned lane_width(input int unsigned ratio);
        return (ratio <= 1) ? 1 : $clog2(ratio);
    endfunction

endpackage

// File: rtl/kernel_cc_fifo_rd_s_skidbuf.sv
// Two-entry register buffer: push at tail, pop at head, occupancy 0..2.
module kernel_cc_fifo_rd_s_skidbuf
    import kernel_cc_fifo_rd_s_pkg::*;
#(
    parameter int unsigned WIDTH = KCC_FIFO_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [1:0]       cnt,
    output logic [WIDTH-1:0] head
);

    logic [WIDTH-1:0] e0;
    logic [WIDTH-1:0] e1;

    assign head = e0;

    // Callers never push when full nor pop when empty.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
            e0  <= '0;
            e1  <= '0;
        end else begin
            unique case ({push, pop})
                2'b10: begin
                    if (cnt == 2'd0) e0 <= push_data;
                    else             e1 <= push_data;
                    cnt <= cnt + 2'd1;
                end
                2'b01: begin
                    e0  <= e1;
                    cnt <= cnt - 2'd1;
                end
                2'b11: begin
                    if (cnt == 2'd1) begin
                        e0 <= push_data;
                    end else begin
                        e0 <= e1;
                        e1 <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/kernel_cc_fifo_rd_s.sv
// Pops kernel_cc FIFO words, slices them LSB-first onto a valid/ready stream with tlast.
module kernel_cc_fifo_rd_s
    import kernel_cc_fifo_rd_s_pkg::*;
#(
    parameter int unsigned IN_WIDTH  = KCC_FIFO_W,
    parameter int unsigned OUT_WIDTH = KCC_BEAT_W,
    parameter int unsigned LEN_WIDTH = KCC_LEN_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic                 fifo_empty_n,
    input  logic [IN_WIDTH-1:0]  fifo_dout,
    output logic                 fifo_read,
    output logic                 fifo_read_ce,
    input  logic [LEN_WIDTH-1:0] cfg_len,
    output logic                 m_tvalid,
    input  logic                 m_tready,
    output logic [OUT_WIDTH-1:0] m_tdata,
    output logic                 m_tlast,
    output logic [31:0]          words_popped
);

    localparam int unsigned RATIO  = IN_WIDTH / OUT_WIDTH;
    localparam int unsigned LANE_W = lane_width(RATIO);
    localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(RATIO - 1);

    logic [1:0]           cnt;
    logic [IN_WIDTH-1:0]  head;
    logic [LANE_W-1:0]    lane;
    logic [LEN_WIDTH-1:0] bc;
    logic                 accept;
    logic                 free_head;

    // Pop decision uses only registered occupancy, keeping m_tready off this path.
    assign fifo_read    = ~reset & en & fifo_empty_n & (cnt < 2'd2);
    assign fifo_read_ce = ~reset;

    assign m_tvalid  = (cnt != 2'd0);
    assign accept    = m_tvalid & m_tready;
    assign free_head = accept & (lane == LANE_LAST);
    assign m_tlast   = m_tvalid & (cfg_len != '0) & (bc == cfg_len - LEN_WIDTH'(1));

    always_comb begin
        m_tdata = '0;
        for (int unsigned i = 0; i < RATIO; i++) begin
            if (lane == LANE_W'(i)) m_tdata = head[i*OUT_WIDTH +: OUT_WIDTH];
        end
    end

    kernel_cc_fifo_rd_s_skidbuf #(
        .WIDTH (IN_WIDTH)
    ) u_buf (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_read),
        .push_data (fifo_dout),
        .pop       (free_head),
        .cnt       (cnt),
        .head      (head)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            lane         <= '0;
            bc           <= '0;
            words_popped <= '0;
        end else begin
            if (accept) begin
                lane <= free_head ? '0 : lane + LANE_W'(1);
                bc   <= m_tlast ? '0 : bc + LEN_WIDTH'(1);
            end
            if (fifo_read) words_popped <= words_popped + 32'd1;
        end
    end

endmodule

// File: tb/tb_kernel_cc_fifo_rd_s.sv
// Randomized self-checking bench: beat-queue model of the FIFO-to-stream slicer.
module tb_kernel_cc_fifo_rd_s;

    localparam int unsigned RATIO = 2;

    logic        clk = 1'b0;
    logic        reset, en, fifo_empty_n, fifo_read, fifo_read_ce;
    logic [63:0] fifo_dout;
    logic [15:0] cfg_len;
    logic        m_tvalid, m_tready, m_tlast;
    logic [31:0] m_tdata, words_popped;

    kernel_cc_fifo_rd_s #(
        .IN_WIDTH  (64),
        .OUT_WIDTH (32),
        .LEN_WIDTH (16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .en           (en),
        .fifo_empty_n (fifo_empty_n),
        .fifo_dout    (fifo_dout),
        .fifo_read    (fifo_read),
        .fifo_read_ce (fifo_read_ce),
        .cfg_len      (cfg_len),
        .m_tvalid     (m_tvalid),
        .m_tready     (m_tready),
        .m_tdata      (m_tdata),
        .m_tlast      (m_tlast),
        .words_popped (words_popped)
    );

    always #5 clk = ~clk;

    int unsigned errors = 0, checks = 0, cyc = 0;
    int unsigned rdy_pct = 100, nacc = 0, popped = 0;
    logic        rst_val = 1'b1, en_val = 1'b1;
    logic [15:0] cfg_val = 16'd2;
    bit          armed = 0, fresh = 0;
    bit          p_rst = 0, p_pop = 0, p_acc = 0, p_last = 0;
    logic [63:0] src_q[$];
    logic [31:0] exp_beats[$];
    logic [31:0] acc_d[$];
    bit          acc_l[$];
    int unsigned acc_cyc[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cycle();
        logic [63:0] w;
        logic [31:0] b;
        bit exp_rd, exp_valid, exp_last;
        @(negedge clk);
        cyc++;
        if (p_rst) begin
            exp_beats.delete();
            nacc = 0; popped = 0; fresh = 1; armed = 1;
        end else begin
            if (p_acc) begin
                b = exp_beats.pop_front();
                acc_d.push_back(b); acc_l.push_back(p_last); acc_cyc.push_back(cyc);
                nacc++;
            end
            if (p_pop) begin
                w = src_q.pop_front();
                for (int unsigned i = 0; i < RATIO; i++) exp_beats.push_back(w[i*32 +: 32]);
                popped++; fresh = 0;
            end
        end
        reset        = rst_val;
        en           = en_val;
        cfg_len      = cfg_val;
        m_tready     = ($urandom_range(0, 99) < rdy_pct);
        fifo_empty_n = (src_q.size() != 0);
        fifo_dout    = (src_q.size() != 0) ? src_q[0] : {$urandom, $urandom};
        #1;
        exp_valid = (exp_beats.size() != 0);
        exp_rd    = !reset && en && fifo_empty_n && ((exp_beats.size() + RATIO - 1) / RATIO < 2);
        exp_last  = exp_valid && (cfg_val != 0) && ((nacc % cfg_val) == cfg_val - 1);
        if (armed) begin
            chk("fifo_read", fifo_read, exp_rd);
            chk("fifo_read_ce", fifo_read_ce, !reset);
            chk("m_tvalid", m_tvalid, exp_valid);
            chk("words_popped", words_popped, popped);
            if (exp_valid) begin
                chk("m_tdata", m_tdata, exp_beats[0]);
                chk("m_tlast", m_tlast, exp_last);
            end
            if (fresh) begin
                chk("reset_tdata", m_tdata, 0);
                chk("reset_tlast", m_tlast, 0);
            end
        end
        p_rst  = reset;
        p_pop  = exp_rd;
        p_acc  = exp_valid && m_tready && !reset;
        p_last = exp_last;
    endtask

    task automatic run(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) cycle();
    endtask

    task automatic drain(input int unsigned budget);
        int unsigned n = 0;
        while (((en_val && src_q.size() != 0) || exp_beats.size() != 0 || p_pop || p_acc)
               && n < budget) begin
            cycle();
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL drain_timeout: got %0d cycles expected under %0d", n, budget);
        end
    endtask

    initial begin
        int unsigned base, base_pop, nlast;
        logic [63:0] words[$];
        logic [63:0] w6[3];

        // 1: reset, then idle with empty FIFO
        run(3);
        rst_val = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            chk("p1_read", fifo_read, 0);
            chk("p1_valid", m_tvalid, 0);
            chk("p1_popped", words_popped, 0);
        end

        // 2: single word, packet of 2
        base = acc_d.size();
        src_q.push_back(64'h11112222_33334444);
        drain(20);
        chk("p2_beat0", acc_d[base], 32'h33334444);
        chk("p2_last0", acc_l[base], 0);
        chk("p2_beat1", acc_d[base+1], 32'h11112222);
        chk("p2_last1", acc_l[base+1], 1);
        chk("p2_popped", words_popped, 1);

        // 3: 100 back-to-back words
        base = acc_d.size();
        for (int i = 0; i < 100; i++) src_q.push_back({$urandom, $urandom});
        drain(400);
        nlast = 0;
        for (int unsigned i = base; i < acc_l.size(); i++) nlast += acc_l[i];
        chk("p3_beats", acc_d.size() - base, 200);
        chk("p3_tlasts", nlast, 100);
        chk("p3_nogap", acc_cyc[acc_cyc.size()-1] - acc_cyc[base] + 1, 200);
        chk("p3_popped", words_popped, 101);

        // 4: backpressure with deep FIFO, then random release
        base = acc_d.size();
        base_pop = words_popped;
        rdy_pct = 0;
        words.delete();
        for (int i = 0; i < 10; i++) begin
            words.push_back({$urandom, $urandom});
            src_q.push_back(words[i]);
        end
        run(20);
        chk("p4_pops", words_popped - base_pop, 2);
        chk("p4_read_off", fifo_read, 0);
        rdy_pct = 70;
        drain(300);
        chk("p4_beats", acc_d.size() - base, 20);
        for (int unsigned i = 0; i < 20; i++)
            chk("p4_order", acc_d[base+i], words[i/2][(i%2)*32 +: 32]);

        // 5: cfg_len=3 across word boundaries, en dropped after two words
        rdy_pct = 100;
        cfg_val = 16'd3;
        nacc = 0;
        base = acc_d.size();
        src_q.push_back({$urandom, $urandom});
        src_q.push_back({$urandom, $urandom});
        drain(50);
        en_val = 1'b0;
        base_pop = words_popped;
        src_q.push_back({$urandom, $urandom});
        src_q.push_back({$urandom, $urandom});
        run(10);
        chk("p5_en_off_pops", words_popped, base_pop);
        chk("p5_drained", acc_d.size() - base, 4);
        en_val = 1'b1;
        drain(50);
        chk("p5_last_b1", acc_l[base], 0);
        chk("p5_last_b3", acc_l[base+2], 1);
        chk("p5_last_b6", acc_l[base+5], 1);
        chk("p5_last_b7", acc_l[base+6], 0);
        chk("p5_last_b8", acc_l[base+7], 0);

        // 6: reset with cnt=2, lane=1, bc=1
        rst_val = 1'b1;
        cfg_val = 16'd2;
        run(2);
        rst_val = 1'b0;
        rdy_pct = 0;
        for (int i = 0; i < 3; i++) begin
            w6[i] = {$urandom, $urandom};
            src_q.push_back(w6[i]);
        end
        run(6);
        chk("p6_pops", words_popped, 2);
        rdy_pct = 100;
        cycle();
        rdy_pct = 0;
        cycle();
        chk("p6_pre_tdata", m_tdata, w6[0][63:32]);
        chk("p6_pre_tlast", m_tlast, 1);
        rst_val = 1'b1;
        run(2);
        chk("p6_rst_valid", m_tvalid, 0);
        chk("p6_rst_tlast", m_tlast, 0);
        chk("p6_rst_tdata", m_tdata, 0);
        chk("p6_rst_popped", words_popped, 0);
        chk("p6_rst_read", fifo_read, 0);
        chk("p6_rst_ce", fifo_read_ce, 0);
        rst_val = 1'b0;
        rdy_pct = 100;
        base = acc_d.size();
        drain(30);
        chk("p6_post_data", acc_d[base], w6[2][31:0]);
        chk("p6_post_last0", acc_l[base], 0);
        chk("p6_post_last1", acc_l[base+1], 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
